// File: rtl/madd_pkg.sv
// madd_pkg: shared opcodes, sequencer states and default widths for the multiply-add core
package madd_pkg;

    localparam int MADD_IDX_W  = 4;
    localparam int MADD_DATA_W = 4;

    localparam logic [1:0] OP_LOAD_AT   = 2'b00;
    localparam logic [1:0] OP_LOAD_NEXT = 2'b01;
    localparam logic [1:0] OP_RUN       = 2'b10;
    localparam logic [1:0] OP_CLR_PTR   = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} seq_state_t;

endpackage

// File: rtl/madd_lat_counter.sv
// madd_lat_counter: loadable down-counter with zero flag, times the core run latency
module madd_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // load wins over decrement; decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/madd_cmd_sequencer.sv
// madd_cmd_sequencer: command front end issuing load/run strobes to the multiply-add core (option: MADD_SEQ_AUTORUN_EN)
module madd_cmd_sequencer
    import madd_pkg::*;
#(
    parameter int IDX_W   = MADD_IDX_W,
    parameter int DATA_W  = MADD_DATA_W,
    parameter int DEPTH   = 16,
    parameter int RUN_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_index,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [1:0]        cmd_insn,
    output logic              mac_load,
    output logic              mac_run,
    output logic [1:0]        mac_insn,
    output logic [IDX_W-1:0]  mac_index,
    output logic [DATA_W-1:0] mac_data,
    output logic [IDX_W-1:0]  ptr,
    output logic              busy,
    output logic              done
);

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       LAT_INIT = 4'(RUN_LAT - 1);

    seq_state_t        state_q;
    logic              mac_load_q, mac_run_q, busy_q, done_q;
    logic [1:0]        mac_insn_q;
    logic [IDX_W-1:0]  mac_index_q, ptr_q;
    logic [DATA_W-1:0] mac_data_q;
    logic [3:0]        lat_cnt;
    logic              lat_zero;
`ifdef MADD_SEQ_AUTORUN_EN
    logic              wrap_q;
`endif

    madd_lat_counter #(.W(4)) u_lat (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == RUN),
        .val_i  (LAT_INIT),
        .dec_i  (state_q == WAIT),
        .cnt_o  (lat_cnt),
        .zero_o (lat_zero)
    );

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign mac_load  = mac_load_q;
    assign mac_run   = mac_run_q;
    assign mac_insn  = mac_insn_q;
    assign mac_index = mac_index_q;
    assign mac_data  = mac_data_q;
    assign ptr       = ptr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // sequencer FSM; strobes and done are one-cycle registered pulses, done is raised one edge early so it lines up with the zero count
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mac_load_q  <= 1'b0;
            mac_run_q   <= 1'b0;
            mac_insn_q  <= '0;
            mac_index_q <= '0;
            mac_data_q  <= '0;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MADD_SEQ_AUTORUN_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            mac_load_q <= 1'b0;
            mac_run_q  <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_LOAD_AT || cmd_op == OP_LOAD_NEXT) begin
                            state_q     <= LOAD;
                            busy_q      <= 1'b1;
                            mac_load_q  <= 1'b1;
                            mac_data_q  <= cmd_data;
                            mac_index_q <= (cmd_op == OP_LOAD_AT) ? cmd_index : ptr_q;
                        end
                        if (cmd_op == OP_LOAD_NEXT || cmd_op == OP_CLR_PTR)
                            ptr_q <= (cmd_op == OP_CLR_PTR || ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
                        if (cmd_op == OP_RUN) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            mac_run_q  <= 1'b1;
                            mac_insn_q <= cmd_insn;
                        end
`ifdef MADD_SEQ_AUTORUN_EN
                        wrap_q <= (cmd_op == OP_LOAD_NEXT) && (ptr_q == PTR_MAX);
`endif
                    end
                end
                LOAD: begin
`ifdef MADD_SEQ_AUTORUN_EN
                    if (wrap_q) begin
                        state_q   <= RUN;
                        mac_run_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                RUN: begin
                    state_q <= WAIT;
                    done_q  <= (RUN_LAT == 1);
                end
                WAIT: begin
                    if (lat_zero) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= (lat_cnt == 4'd1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_madd_cmd_sequencer.sv
// tb_madd_cmd_sequencer: directed and random commands checked against a cycle-schedule reference model
module tb_madd_cmd_sequencer;

    localparam int IDX_W   = 4;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 16;
    localparam int RUN_LAT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [IDX_W-1:0]  cmd_index = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic [1:0]        cmd_insn = '0;
    logic              mac_load, mac_run, busy, done;
    logic [1:0]        mac_insn;
    logic [IDX_W-1:0]  mac_index, ptr;
    logic [DATA_W-1:0] mac_data;

    int n_chk = 0;
    int n_bad = 0;

    // reference model: absolute cycle numbers at which each effect is due
    int k = 0;
    int busy_until = -1;
    int load_c = -1, run_c = -1, done_c = -1;
    int m_ptr = 0, m_idx = 0, m_dat = 0, m_ins = 0;
    int acc_n = 0;

    always #5 clk = ~clk;

    madd_cmd_sequencer #(
        .IDX_W(IDX_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RUN_LAT(RUN_LAT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_index(cmd_index), .cmd_data(cmd_data), .cmd_insn(cmd_insn),
        .mac_load(mac_load), .mac_run(mac_run), .mac_insn(mac_insn),
        .mac_index(mac_index), .mac_data(mac_data), .ptr(ptr), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // one cycle: check the DUT against the model, then drive the next inputs and advance the model
    task automatic step(input bit v, input bit [1:0] op, input bit [3:0] ix, input bit [3:0] dt,
                        input bit [1:0] in, input bit r);
        @(negedge clk);
        check("ready", cmd_ready, (!rst && k > busy_until) ? 1 : 0);
        check("busy", busy, (k <= busy_until) ? 1 : 0);
        check("load", mac_load, (k == load_c) ? 1 : 0);
        check("run", mac_run, (k == run_c) ? 1 : 0);
        check("done", done, (k == done_c) ? 1 : 0);
        check("index", mac_index, m_idx);
        check("data", mac_data, m_dat);
        check("insn", mac_insn, m_ins);
        check("ptr", ptr, m_ptr);
        check("excl", mac_load & mac_run, 0);
        rst = r; cmd_valid = v; cmd_op = op; cmd_index = ix; cmd_data = dt; cmd_insn = in;
        if (r) begin
            m_ptr = 0; m_idx = 0; m_dat = 0; m_ins = 0;
            load_c = -1; run_c = -1; done_c = -1; busy_until = k;
        end else if (v && k > busy_until) begin
            acc_n++;
            case (op)
                2'd0: begin load_c = k + 1; m_idx = ix; m_dat = dt; busy_until = k + 1; end
                2'd1: begin
                    load_c = k + 1; m_idx = m_ptr; m_dat = dt; busy_until = k + 1;
                    if (m_ptr == DEPTH - 1) begin
                        m_ptr = 0;
`ifdef MADD_SEQ_AUTORUN_EN
                        run_c = k + 2; done_c = k + 2 + RUN_LAT; busy_until = done_c;
`endif
                    end else m_ptr++;
                end
                2'd2: begin run_c = k + 1; m_ins = in; done_c = k + 1 + RUN_LAT; busy_until = done_c; end
                default: m_ptr = 0;
            endcase
        end
        k++;
    endtask

    // hold a command until accepted, bounded
    task automatic issue(input bit [1:0] op, input bit [3:0] ix, input bit [3:0] dt, input bit [1:0] in);
        int n0 = acc_n;
        for (int t = 0; t < 40 && acc_n == n0; t++) step(1, op, ix, dt, in, 0);
        check("accept_timeout", acc_n, n0 + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        issue(2'd0, 4'd5, 4'hA, 2'd0);
        idle(3);
        for (int i = 0; i < 17; i++) issue(2'd1, 4'd0, 4'(i), 2'd0);
        idle(2);
        issue(2'd2, 4'd0, 4'd0, 2'd2);
        idle(8);
        for (int i = 0; i < 3; i++) issue(2'd1, 4'd0, 4'(i + 3), 2'd0);
        issue(2'd3, 4'd0, 4'd0, 2'd0);
        idle(2);
        issue(2'd1, 4'd0, 4'h7, 2'd0);
        idle(2);
        issue(2'd2, 4'd0, 4'd0, 2'd3);
        idle(2);
        step(0, 0, 0, 0, 0, 1);
        idle(8);
        issue(2'd3, 4'd0, 4'd0, 2'd0);
        issue(2'd2, 4'd0, 4'd0, 2'd1);
        for (int i = 0; i < 16; i++) issue(2'd1, 4'd0, 4'(i), 2'd0);
        idle(10);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                 2'($urandom_range(0, 3)), $urandom_range(0, 99) == 0);
        idle(10);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
